ysyx_22050039_lsu: RTL and testbench

//  Load/store unit directly downstream of the execute stage. Takes the EXU result
//  (effective address, or a pass-through value) plus store data, runs one access on the

---
 rtl/ysyx_22050039_lsu.sv | 162 ++++++++++++++++
 tb/tb_ysyx_22050039_lsu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050039_lsu.sv
// Load/store unit: accepts one EXU op, runs at most one data-memory access and
// returns a single write-back result (data, destination, enable, error code).
module ysyx_22050039_lsu #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [4:0]      in_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic [1:0]      out_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MEM    = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]      state;
    logic [7:0]      cnt;
    logic [1:0]      size_q;
    logic            uns_q;
    logic            load_q;
    logic [2:0]      off_q;
    logic [4:0]      rd_q;
    logic            wen_q;

    logic            accept;
    logic            is_mem;
    logic            misal;
    logic [7:0]      bmask;
    logic [2:0]      amask;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ld_ext;

    assign in_ready  = (state == S_IDLE) | ((state == S_RESP) & out_ready);
    assign accept    = in_valid & in_ready;
    assign mem_req   = (state == S_MEM);
    assign out_valid = (state == S_RESP);
    assign out_wen   = (state == S_RESP) & wen_q;
    assign is_mem    = (in_op == OP_LOAD) | (in_op == OP_STORE);
    assign misal     = |(in_addr[2:0] & amask);
    assign shifted   = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        bmask = 8'h01;
        amask = 3'b000;
        case (in_size)
            2'd0: begin bmask = 8'h01; amask = 3'b000; end
            2'd1: begin bmask = 8'h03; amask = 3'b001; end
            2'd2: begin bmask = 8'h0f; amask = 3'b011; end
            default: begin bmask = 8'hff; amask = 3'b111; end
        endcase
    end

    always_comb begin
        ld_ext = shifted;
        case (size_q)
            2'd0: ld_ext = uns_q ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                 : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            2'd1: ld_ext = uns_q ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                 : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            2'd2: ld_ext = uns_q ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                 : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            default: ld_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            load_q    <= 1'b0;
            off_q     <= '0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            out_data  <= '0;
            out_rd    <= '0;
            out_err   <= '0;
        end else begin
            case (state)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        if (!is_mem) begin
                            state    <= S_RESP;
                            out_data <= in_addr;
                            out_err  <= 2'd0;
                            wen_q    <= (in_rd != 5'd0);
                            out_rd   <= in_rd;
                        end else if (misal) begin
                            state    <= S_RESP;
                            out_data <= '0;
                            out_err  <= 2'd1;
                            wen_q    <= 1'b0;
                            out_rd   <= in_rd;
                        end else begin
                            // out_* stay untouched until the access resolves
                            state     <= S_MEM;
                            cnt       <= '0;
                            size_q    <= in_size;
                            uns_q     <= in_unsigned;
                            load_q    <= (in_op == OP_LOAD);
                            off_q     <= in_addr[2:0];
                            rd_q      <= in_rd;
                            mem_we    <= (in_op == OP_STORE);
                            mem_addr  <= {in_addr[XLEN-1:3], 3'b000};
                            mem_wdata <= in_wdata << {in_addr[2:0], 3'b000};
                            mem_wmask <= bmask << in_addr[2:0];
                        end
                    end else if (state == S_RESP && out_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state    <= S_RESP;
                        out_data <= load_q ? ld_ext : '0;
                        out_err  <= 2'd0;
                        wen_q    <= load_q & (rd_q != 5'd0);
                        out_rd   <= rd_q;
                    end else if (cnt == TMO_LAST) begin
                        state    <= S_RESP;
                        out_data <= '0;
                        out_err  <= 2'd2;
                        wen_q    <= 1'b0;
                        out_rd   <= rd_q;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// Randomized self-checking bench for ysyx_22050039_lsu with a behavioural
// reference for load extension, byte masks, misalignment and bus timeout.
module tb_ysyx_22050039_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_unsigned;
    logic [1:0]  in_op, in_size;
    logic [63:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req, mem_we, mem_ready;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        out_valid, out_ready, out_wen;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic [1:0]  out_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_22050039_lsu #(.XLEN(64), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_wen(out_wen), .out_err(out_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] rdata, input int off,
                                             input int nb, input bit uns);
        logic [63:0] v, lim;
        v = rdata >> (8 * off);
        if (nb < 8) begin
            lim = (64'd1 << (8 * nb)) - 64'd1;
            v   = v & lim;
            if (!uns && v[8*nb-1]) v = v | ~lim;
        end
        return v;
    endfunction

    // d = waiting cycles before mem_ready; d >= 255 means the bus never answers
    task automatic do_op(input logic [1:0] op, input logic [1:0] size, input bit uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [4:0] rd, input int d, input logic [63:0] rdata,
                         input int hold);
        int          nb, off, w;
        bit          is_mem, mis, tmo, exp_wen;
        logic [1:0]  exp_err;
        logic [63:0] exp_data;
        logic [7:0]  exp_mask;
        nb       = 1 << size;
        off      = int'(addr[2:0]);
        is_mem   = (op == 2'd1) || (op == 2'd2);
        mis      = is_mem && ((off % nb) != 0);
        tmo      = is_mem && !mis && (d >= 255);
        exp_mask = 8'(((1 << nb) - 1) << off);

        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_op = op; in_size = size; in_unsigned = uns; in_addr = addr;
        in_wdata = wdata; in_rd = rd; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_addr  = {$urandom, $urandom};
        in_wdata = {$urandom, $urandom};

        if (is_mem && !mis) begin
            check("mem_req", 64'(mem_req), 64'd1);
            check("mem_we", 64'(mem_we), 64'(op == 2'd2));
            check("mem_addr", mem_addr, {addr[63:3], 3'b000});
            check("mem_wmask", 64'(mem_wmask), 64'(exp_mask));
            if (op == 2'd2) check("mem_wdata", mem_wdata, wdata << (8 * off));
            w = 0;
            while (w < d && w < 255) begin
                check("mem_req_hold", 64'(mem_req), 64'd1);
                check("out_valid_wait", 64'(out_valid), 64'd0);
                step();
                w++;
            end
            if (!tmo) begin
                mem_rdata = rdata;
                mem_ready = 1'b1;
                step();
                mem_ready = 1'b0;
                mem_rdata = {$urandom, $urandom};
            end
        end else begin
            check("no_mem_req", 64'(mem_req), 64'd0);
        end

        exp_err  = mis ? 2'd1 : (tmo ? 2'd2 : 2'd0);
        exp_data = (exp_err != 2'd0 || op == 2'd2) ? 64'd0
                 : (is_mem ? ref_load(rdata, off, nb, uns) : addr);
        exp_wen  = (exp_err == 2'd0) && (op != 2'd2) && (rd != 5'd0);

        check("out_valid", 64'(out_valid), 64'd1);
        check("out_data", out_data, exp_data);
        check("out_err", 64'(out_err), 64'(exp_err));
        check("out_wen", 64'(out_wen), 64'(exp_wen));
        check("out_rd", 64'(out_rd), 64'(rd));
        check("mem_req_done", 64'(mem_req), 64'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", out_data, exp_data);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("idle_after", 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] a [8];
        logic [63:0] addr;
        logic [2:0]  am;
        logic [1:0]  size;

        rst = 1'b0; in_valid = 1'b0; in_op = '0; in_size = '0; in_unsigned = 1'b0;
        in_addr = '0; in_wdata = '0; in_rd = '0; mem_ready = 1'b0; mem_rdata = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_wen", 64'(out_wen), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_mem_wmask", 64'(mem_wmask), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        rst = 1'b1;
        step();

        do_op(2'd1, 2'd3, 1'b0, 64'h8000_0008, 64'd0, 5'd5, 2, 64'h1122_3344_5566_7788, 1);
        do_op(2'd1, 2'd0, 1'b0, 64'h8000_0003, 64'd0, 5'd6, 0, 64'h0000_0000_80FF_0000, 0);
        do_op(2'd1, 2'd0, 1'b1, 64'h8000_0003, 64'd0, 5'd6, 1, 64'h0000_0000_80FF_0000, 0);
        do_op(2'd2, 2'd1, 1'b0, 64'h8000_0006, 64'hABCD, 5'd7, 1, 64'd0, 0);
        do_op(2'd1, 2'd2, 1'b0, 64'h8000_0002, 64'd0, 5'd8, 0, 64'd0, 1);
        do_op(2'd1, 2'd2, 1'b0, 64'h8000_0004, 64'd0, 5'd9, 1000, 64'd0, 0);
        do_op(2'd1, 2'd1, 1'b0, 64'h8000_0002, 64'd0, 5'd10, 254, 64'h0000_8001_0000_0000, 0);
        do_op(2'd3, 2'd0, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'd0, 5'd0, 0, 64'd0, 0);

        // streamed PASS ops: one result per cycle with no bubble
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) a[i] = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            check("stream_in_ready", 64'(in_ready), 64'd1);
            in_op = 2'd0; in_addr = a[i]; in_rd = 5'(i + 1); in_valid = 1'b1;
            step();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data", out_data, a[i]);
            check("stream_rd", 64'(out_rd), 64'(i + 1));
        end
        in_valid = 1'b0;
        step();
        check("stream_idle", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // reset while an access is outstanding
        in_op = 2'd1; in_size = 2'd3; in_addr = 64'h8000_0010; in_rd = 5'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("pre_rst_mem_req", 64'(mem_req), 64'd1);
        step();
        rst = 1'b0;
        #1;
        check("rst_mid_mem_req", 64'(mem_req), 64'd0);
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        #2 rst = 1'b1;
        step();
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check("rst_mid_no_result", 64'(out_valid), 64'd0);

        for (int n = 0; n < 150; n++) begin
            size = 2'($urandom_range(0, 3));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) begin
                am = 3'((1 << size) - 1);
                addr[2:0] = addr[2:0] & ~am;
            end
            do_op(2'($urandom_range(0, 3)), size, 1'($urandom_range(0, 1)), addr,
                  {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3), {$urandom, $urandom}, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
